// File: rtl/tick_color_sequencer_pkg.sv
// Shared types and constants for the color tick consumer: FSM states,
// default widths and the RGB888 palette lookup.
package tick_pkg;

   localparam int NUM_COLORS_DEF     = 8;
   localparam int COLOR_W_DEF        = 24;
   localparam int CNT_W_DEF          = 26;
   localparam int TIMEOUT_CYCLES_DEF = 40000000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

   // Indices past 7 reuse the base eight colors.
   function automatic logic [23:0] palette(input int unsigned idx);
      case (idx % 8)
         0:       palette = 24'h000000;
         1:       palette = 24'hFF0000;
         2:       palette = 24'hFF8000;
         3:       palette = 24'hFFFF00;
         4:       palette = 24'h00FF00;
         5:       palette = 24'h00FFFF;
         6:       palette = 24'h0000FF;
         default: palette = 24'hFFFFFF;
      endcase
   endfunction

endpackage

// File: rtl/tick_edge_meter.sv
// Detects toggles of the tick level and measures the toggle-to-toggle spacing.
// timeout_o flags the last counted cycle in RUN without a toggle.
module tick_edge_meter
   import tick_pkg::*;
#(
   parameter int CNT_W          = CNT_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             tick_i,
   input  logic             clear_i,
   input  logic             run_i,
   input  logic             stall_i,
   output logic             edge_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] half_period_o,
   output logic             period_valid_o
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic             tick_d_q;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             armed_q, armed_d;
   logic [CNT_W-1:0] hp_q, hp_d;
   logic             pv_q, pv_d;

   assign edge_o         = tick_i ^ tick_d_q;
   assign cnt_inc        = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   assign timeout_o      = run_i && !edge_o && (cnt_q == TO_LAST);
   assign half_period_o  = hp_q;
   assign period_valid_o = pv_q;

   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      hp_d    = hp_q;
      pv_d    = pv_q;
      if (clear_i) begin
         cnt_d   = '0;
         armed_d = 1'b0;
         pv_d    = 1'b0;
      end else if (run_i) begin
         if (edge_o) begin
            cnt_d   = '0;
            armed_d = 1'b1;
            // cnt_inc is cnt+1 saturated, i.e. cycles since the previous toggle
            if (armed_q) begin
               hp_d = cnt_inc;
               pv_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_inc;
            if (timeout_o) begin
               armed_d = 1'b0;
               pv_d    = 1'b0;
            end
         end
      end else if (stall_i && edge_o) begin
         cnt_d   = '0;
         armed_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tick_d_q <= 1'b0;
         cnt_q    <= '0;
         armed_q  <= 1'b0;
         hp_q     <= '0;
         pv_q     <= 1'b0;
      end else begin
         tick_d_q <= tick_i;
         cnt_q    <= cnt_d;
         armed_q  <= armed_d;
         hp_q     <= hp_d;
         pv_q     <= pv_d;
      end
   end

endmodule

// File: rtl/tick_color_sequencer.sv
// Steps a palette index/RGB register on each tick toggle while running,
// or on a manual step request; tracks IDLE/RUN/STALL of the tick source.
module tick_color_sequencer
   import tick_pkg::*;
#(
   parameter int NUM_COLORS     = NUM_COLORS_DEF,
   parameter int COLOR_W        = COLOR_W_DEF,
   parameter int CNT_W          = CNT_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tick_color,
   input  logic                          enable,
   input  logic                          step_req,
   output logic [$clog2(NUM_COLORS)-1:0] color_idx,
   output logic [COLOR_W-1:0]            color_out,
   output logic                          color_strobe,
   output logic [CNT_W-1:0]              half_period,
   output logic                          period_valid,
   output logic                          stall,
   output state_t                        state_o
);

   localparam int               IDX_W    = $clog2(NUM_COLORS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_COLORS - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [COLOR_W-1:0] color_q, color_d;
   logic             strobe_q;
   logic             tick_edge, timeout;
   logic             clear, run, in_stall, advance;

   tick_edge_meter #(
      .CNT_W         (CNT_W),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_meter (
      .clk_i         (clk),
      .reset_i       (reset),
      .tick_i        (tick_color),
      .clear_i       (clear),
      .run_i         (run),
      .stall_i       (in_stall),
      .edge_o        (tick_edge),
      .timeout_o     (timeout),
      .half_period_o (half_period),
      .period_valid_o(period_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (timeout) state_d = STALL;
            STALL:   if (tick_edge) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   // Toggles only advance the color while running and enabled; the stall
   // recovery toggle deliberately does not.
   always_comb begin
      clear    = !enable || (state_q == IDLE);
      run      = (state_q == RUN);
      in_stall = (state_q == STALL);
      stall    = in_stall;
      advance  = step_req || (run && enable && tick_edge);
   end

   always_comb begin
      idx_d   = idx_q;
      color_d = color_q;
      if (advance) begin
         idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
         color_d = COLOR_W'(palette(32'(idx_d)));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q    <= '0;
         color_q  <= COLOR_W'(palette(0));
         strobe_q <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         color_q  <= color_d;
         strobe_q <= advance;
      end
   end

   assign color_idx    = idx_q;
   assign color_out    = color_q;
   assign color_strobe = strobe_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_tick_color_sequencer.sv
// Bench for tick_color_sequencer: directed vector table, hand-written
// multi-cycle sequences and random stimulus against a timestamp-based model.
module tb_tick_color_sequencer;
   import tick_pkg::*;

   localparam int NUM_COLORS = 8;
   localparam int COLOR_W    = 24;
   localparam int CNT_W      = 8;
   localparam int TIMEOUT    = 20;
   localparam int W          = 40;

   localparam logic [23:0] PAL [8] = '{24'h000000, 24'hFF0000, 24'hFF8000, 24'hFFFF00,
                                       24'h00FF00, 24'h00FFFF, 24'h0000FF, 24'hFFFFFF};

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               tick_color = 1'b0;
   logic               enable = 1'b0;
   logic               step_req = 1'b0;
   logic [2:0]         color_idx;
   logic [COLOR_W-1:0] color_out;
   logic               color_strobe;
   logic [CNT_W-1:0]   half_period;
   logic               period_valid;
   logic               stall;
   state_t             state_o;

   always #5 clk = ~clk;

   tick_color_sequencer #(
      .NUM_COLORS    (NUM_COLORS),
      .COLOR_W       (COLOR_W),
      .CNT_W         (CNT_W),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tick_color  (tick_color),
      .enable      (enable),
      .step_req    (step_req),
      .color_idx   (color_idx),
      .color_out   (color_out),
      .color_strobe(color_strobe),
      .half_period (half_period),
      .period_valid(period_valid),
      .stall       (stall),
      .state_o     (state_o)
   );

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   // Model: remembers the cycle of the last toggle (or RUN entry) instead of a counter.
   state_t     m_mode = IDLE;
   logic       m_prev = 1'b0;
   logic [2:0] m_idx = '0;
   logic       m_strobe = 1'b0;
   logic [7:0] m_hp = '0;
   logic       m_pv = 1'b0;
   logic       m_armed = 1'b0;
   int         m_ref = 0;
   int         cyc = 0;

   task automatic model_step(input logic r, input logic t, input logic e, input logic s);
      logic tgl, adv;
      int   gap;
      if (r) begin
         m_mode = IDLE; m_prev = 1'b0; m_idx = '0; m_strobe = 1'b0;
         m_hp = '0; m_pv = 1'b0; m_armed = 1'b0;
      end else begin
         tgl = t ^ m_prev;
         m_prev = t;
         adv = s || (m_mode == RUN && e && tgl);
         m_strobe = adv;
         if (adv) m_idx = 3'((int'(m_idx) + 1) % NUM_COLORS);
         gap = cyc - m_ref;
         if (!e) begin
            m_mode = IDLE; m_armed = 1'b0; m_pv = 1'b0;
         end else if (m_mode == IDLE) begin
            m_mode = RUN; m_ref = cyc; m_armed = 1'b0;
         end else if (m_mode == RUN) begin
            if (tgl) begin
               if (m_armed) begin
                  m_hp = (gap > 255) ? 8'd255 : 8'(gap);
                  m_pv = 1'b1;
               end
               m_armed = 1'b1;
               m_ref = cyc;
            end else if (gap >= TIMEOUT) begin
               m_mode = STALL; m_armed = 1'b0; m_pv = 1'b0;
            end
         end else if (tgl) begin
            m_mode = RUN; m_ref = cyc; m_armed = 1'b1;
         end
      end
      cyc++;
   endtask

   function automatic logic [W-1:0] dut_word();
      return {state_o, color_idx, color_out, color_strobe, half_period, period_valid, stall};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, predict with the model, compare after the edge.
   task automatic cycle(input logic r, input logic t, input logic e, input logic s);
      logic [W-1:0] exp_w;
      reset = r; tick_color = t; enable = e; step_req = s;
      model_step(r, t, e, s);
      exp_q.push_back({m_mode, m_idx, PAL[m_idx], m_strobe, m_hp, m_pv, (m_mode == STALL)});
      @(posedge clk);
      #1;
      exp_w = exp_q.pop_front();
      checks++;
      if (dut_word() !== exp_w) begin
         errors++;
         $display("FAIL scoreboard cyc %0d: got %010h expected %010h", cyc, dut_word(), exp_w);
      end
   endtask

   typedef struct {
      logic       r, t, e, s;
      logic [2:0] idx;
      logic       strb;
      logic [7:0] hp;
      logic       pv, stl;
      state_t     st;
   } vec_t;

   vec_t tbl[14];
   logic t;
   logic en_r;
   int   n;
   int   hold;

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, IDLE};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, IDLE};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, IDLE};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, IDLE};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 8'd0, 1'b0, 1'b0, IDLE};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 8'd0, 1'b0, 1'b0, IDLE};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 8'd0, 1'b0, 1'b0, IDLE};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 8'd0, 1'b0, 1'b0, RUN};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 8'd0, 1'b0, 1'b0, RUN};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 8'd0, 1'b0, 1'b0, RUN};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 8'd2, 1'b1, 1'b0, RUN};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'd2, 1'b1, 1'b0, RUN};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'd2, 1'b0, 1'b0, IDLE};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 8'd2, 1'b0, 1'b0, IDLE};

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].r, tbl[i].t, tbl[i].e, tbl[i].s);
         chk($sformatf("tbl[%0d]", i), 32'(dut_word()),
             32'({tbl[i].st, tbl[i].idx, PAL[tbl[i].idx], tbl[i].strb, tbl[i].hp, tbl[i].pv, tbl[i].stl}));
         chk($sformatf("tbl_hi[%0d]", i), 32'(dut_word() >> 32),
             32'({tbl[i].st, tbl[i].idx, PAL[tbl[i].idx], tbl[i].strb, tbl[i].hp, tbl[i].pv, tbl[i].stl} >> 32));
      end

      // Reset with the tick still toggling, then a steady 10-cycle toggle.
      t = 1'b0;
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_idx", 32'(color_idx), 0);
      chk("rst_color", 32'(color_out), 32'h000000);
      chk("rst_state", 32'(state_o), 32'(IDLE));
      chk("rst_hp", 32'(half_period), 0);
      cycle(1'b0, t, 1'b1, 1'b0);
      chk("run_entry", 32'(state_o), 32'(RUN));
      for (int k = 1; k <= 9; k++) begin
         t = ~t;
         cycle(1'b0, t, 1'b1, 1'b0);
         chk($sformatf("edge%0d_idx", k), 32'(color_idx), k % 8);
         chk($sformatf("edge%0d_color", k), 32'(color_out), 32'(PAL[k % 8]));
         chk($sformatf("edge%0d_strobe", k), 32'(color_strobe), 1);
         if (k >= 2) begin
            chk($sformatf("edge%0d_hp", k), 32'(half_period), 10);
            chk($sformatf("edge%0d_pv", k), 32'(period_valid), 1);
         end else begin
            chk("edge1_pv", 32'(period_valid), 0);
         end
         cycle(1'b0, t, 1'b1, 1'b0);
         chk($sformatf("edge%0d_strobe_end", k), 32'(color_strobe), 0);
         repeat (8) cycle(1'b0, t, 1'b1, 1'b0);
      end

      // Toggle and step_req together advance once.
      t = ~t;
      cycle(1'b0, t, 1'b1, 1'b1);
      chk("both_idx", 32'(color_idx), 2);
      chk("both_strobe", 32'(color_strobe), 1);
      cycle(1'b0, t, 1'b1, 1'b0);
      chk("both_idx_after", 32'(color_idx), 2);
      chk("both_strobe_end", 32'(color_strobe), 0);

      // Stop toggling until the stall timeout.
      n = 0;
      while (!stall && n < 40) begin
         cycle(1'b0, t, 1'b1, 1'b0);
         n++;
      end
      chk("stall_delay", n, 19);
      chk("stall_flag", 32'(stall), 1);
      chk("stall_state", 32'(state_o), 32'(STALL));
      chk("stall_pv", 32'(period_valid), 0);
      chk("stall_idx", 32'(color_idx), 2);
      chk("stall_hp", 32'(half_period), 10);

      // Recovery toggle re-arms only; the following toggle measures.
      t = ~t;
      cycle(1'b0, t, 1'b1, 1'b0);
      chk("recover_stall", 32'(stall), 0);
      chk("recover_idx", 32'(color_idx), 2);
      chk("recover_strobe", 32'(color_strobe), 0);
      chk("recover_pv", 32'(period_valid), 0);
      repeat (9) cycle(1'b0, t, 1'b1, 1'b0);
      t = ~t;
      cycle(1'b0, t, 1'b1, 1'b0);
      chk("remeasure_pv", 32'(period_valid), 1);
      chk("remeasure_hp", 32'(half_period), 10);
      chk("remeasure_idx", 32'(color_idx), 3);

      // Disable mid-run: toggles ignored, manual step still works.
      cycle(1'b0, t, 1'b0, 1'b0);
      chk("dis_state", 32'(state_o), 32'(IDLE));
      chk("dis_pv", 32'(period_valid), 0);
      chk("dis_stall", 32'(stall), 0);
      t = ~t;
      cycle(1'b0, t, 1'b0, 1'b0);
      chk("dis_toggle_idx", 32'(color_idx), 3);
      chk("dis_toggle_strobe", 32'(color_strobe), 0);
      cycle(1'b0, t, 1'b0, 1'b1);
      chk("dis_step_idx", 32'(color_idx), 4);
      chk("dis_step_strobe", 32'(color_strobe), 1);

      // Reset while stalled.
      cycle(1'b0, t, 1'b1, 1'b0);
      n = 0;
      while (!stall && n < 40) begin
         cycle(1'b0, t, 1'b1, 1'b0);
         n++;
      end
      chk("stall2_reached", 32'(stall), 1);
      cycle(1'b1, t, 1'b1, 1'b0);
      chk("rst2_idx", 32'(color_idx), 0);
      chk("rst2_color", 32'(color_out), 32'h000000);
      chk("rst2_strobe", 32'(color_strobe), 0);
      chk("rst2_hp", 32'(half_period), 0);
      chk("rst2_pv", 32'(period_valid), 0);
      chk("rst2_stall", 32'(stall), 0);
      chk("rst2_state", 32'(state_o), 32'(IDLE));

      // Random phase: variable toggle spacing, sticky enable, occasional reset/step.
      en_r = 1'b1;
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         logic r, s;
         if (hold == 0) begin
            t = ~t;
            hold = $urandom_range(1, 26);
         end else begin
            hold--;
         end
         if ($urandom_range(0, 99) == 0) en_r = ~en_r;
         r = ($urandom_range(0, 299) == 0);
         s = ($urandom_range(0, 15) == 0);
         cycle(r, t, en_r, s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
